seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 36 +++
 rtl/hex_to_seg.sv | 11 +
 rtl/seg_scan_driver.sv | 108 ++++++++++
 tb/tb_seg_scan_driver.sv | 130 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment display constants: active-low glyphs (gfedcba, bit 0 = a)
// and the all-off patterns for cathodes and anodes.
package seg_pkg;

  typedef logic [3:0] hexDigit_t;
  typedef logic [6:0] segPattern_t;

  localparam segPattern_t SEG_OFF = 7'b1111111;
  localparam logic [3:0]  AN_OFF  = 4'b1111;

  // Entry n is the glyph for hex value n; the highest entry is listed first.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Slot 0 is the leftmost digit, which sits on the most significant anode bit.
  function automatic logic [3:0] anFor(input logic [1:0] slot);
    return ~(4'b1000 >> slot);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex-to-glyph decoder shared by every hex display in the core.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] pattern
);

  assign pattern = SEG_PATTERNS[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-atomic input snapshots,
// per-slot anti-ghosting blanking and optional leading-zero suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] faA,
  input  logic [3:0] faB,
  input  logic [3:0] faC,
  input  logic [3:0] faD,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cntReg;
  logic [1:0]    idxReg;
  hexDigit_t     snapReg [4];
  logic          snapLzReg;
  logic [3:0]    anReg;
  logic [6:0]    segReg;

  logic          lastCnt;
  logic          frameEnd;
  logic          inBlank;
  logic [3:0]    leadBlank;
  logic [6:0]    rawSeg   [4];
  logic [6:0]    digitSeg [4];
  logic [3:0]    anNext;
  logic [6:0]    segNext;

  assign lastCnt  = (cntReg == CW'(REFRESH_DIV - 1));
  assign frameEnd = lastCnt && (idxReg == 2'd3);

  generate
    if (BLANK_CYCLES == 0) begin : gNoBlank
      assign inBlank = 1'b0;
    end else begin : gBlank
      assign inBlank = (cntReg < CW'(BLANK_CYCLES));
    end
  endgenerate

  // A zero is only "leading" while every digit to its left is also zero.
  always_comb begin
    leadBlank    = 4'b0000;
    leadBlank[0] = snapLzReg && (snapReg[0] == 4'd0);
    leadBlank[1] = leadBlank[0] && (snapReg[1] == 4'd0);
    leadBlank[2] = leadBlank[1] && (snapReg[2] == 4'd0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gDigit
      hex_to_seg uDecode (
        .hex     (snapReg[gi]),
        .pattern (rawSeg[gi])
      );
      assign digitSeg[gi] = leadBlank[gi] ? SEG_OFF : rawSeg[gi];
    end
  endgenerate

  always_comb begin
    anNext  = AN_OFF;
    segNext = SEG_OFF;
    if (!inBlank) begin
      anNext  = anFor(idxReg);
      segNext = digitSeg[idxReg];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cntReg    <= '0;
      idxReg    <= 2'd0;
      snapReg   <= '{default: 4'd0};
      snapLzReg <= 1'b0;
      anReg     <= AN_OFF;
      segReg    <= SEG_OFF;
    end else begin
      cntReg <= lastCnt ? '0 : cntReg + CW'(1);
      if (lastCnt) begin
        idxReg <= idxReg + 2'd1;
      end
      // Capture on the last cycle of slot D so the next frame is coherent.
      if (frameEnd) begin
        snapReg[0] <= faA;
        snapReg[1] <= faB;
        snapReg[2] <= faC;
        snapReg[3] <= faD;
        snapLzReg  <= blank_lz;
      end
      anReg  <= anNext;
      segReg <= segNext;
    end
  end

  assign an         = anReg;
  assign seg        = segReg;
  assign frame_tick = reset && frameEnd;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: REFRESH_DIV=4 with one blank cycle per slot, plus a twin
// instance with no blank cycles sharing the same stimulus.
module tb_seg_scan_driver;

  logic       clock;
  logic       reset;
  logic [3:0] faA, faB, faC, faD;
  logic       blank_lz;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       tick1, tick0;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [3:0] a, b, c, d;
    logic       lz;
    logic [6:0] s0, s1, s2, s3;
  } vec_t;

  vec_t vecs [9];
  vec_t afterReset, resumed;

  localparam logic [3:0] AN_ON [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .faA(faA), .faB(faB), .faC(faC), .faD(faD),
    .blank_lz(blank_lz), .an(an1), .seg(seg1), .frame_tick(tick1)
  );

  seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .faA(faA), .faB(faB), .faC(faC), .faD(faD),
    .blank_lz(blank_lz), .an(an0), .seg(seg0), .frame_tick(tick0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int popcount4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  // One full frame starting on slot A's off cycle; new inputs land mid-frame.
  task automatic runFrame(input vec_t v, input string tag);
    logic [6:0] expSeg [4];
    int slot, phase;
    expSeg[0] = v.s0; expSeg[1] = v.s1; expSeg[2] = v.s2; expSeg[3] = v.s3;
    for (int j = 0; j < 16; j++) begin
      step();
      slot  = j / 4;
      phase = j % 4;
      if (phase == 0) begin
        check($sformatf("%s j%0d an1", tag, j), 32'(an1), 32'h0F);
        check($sformatf("%s j%0d seg1", tag, j), 32'(seg1), 32'h7F);
      end else begin
        check($sformatf("%s j%0d an1", tag, j), 32'(an1), 32'(AN_ON[slot]));
        check($sformatf("%s j%0d seg1", tag, j), 32'(seg1), 32'(expSeg[slot]));
      end
      check($sformatf("%s j%0d an0", tag, j), 32'(an0), 32'(AN_ON[slot]));
      check($sformatf("%s j%0d seg0", tag, j), 32'(seg0), 32'(expSeg[slot]));
      check($sformatf("%s j%0d tick1", tag, j), 32'(tick1), 32'(j == 14));
      check($sformatf("%s j%0d tick0", tag, j), 32'(tick0), 32'(j == 14));
      check($sformatf("%s j%0d onehot1", tag, j), 32'(popcount4(~an1) <= 1), 32'd1);
      if (j == 6) begin
        faA = v.a; faB = v.b; faC = v.c; faD = v.d; blank_lz = v.lz;
      end
      $display("%s j=%0d an1=%b seg1=%b an0=%b seg0=%b tick=%b", tag, j, an1, seg1, an0, seg0, tick1);
    end
  endtask

  initial begin
    // {inputs applied mid-frame, segments expected in the current frame}
    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    vecs[1] = '{4'h0, 4'h0, 4'h7, 4'h0, 1'b1, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    vecs[2] = '{4'h0, 4'h0, 4'h7, 4'h0, 1'b0, 7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000};
    vecs[3] = '{4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000};
    vecs[4] = '{4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110};
    vecs[5] = '{4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
    vecs[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010};
    vecs[7] = '{4'h6, 4'h8, 4'h9, 4'hE, 1'b0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    vecs[8] = '{4'h6, 4'h8, 4'h9, 4'hE, 1'b0, 7'b0000010, 7'b0000000, 7'b0010000, 7'b0000110};
    afterReset = '{4'h6, 4'h8, 4'h9, 4'hE, 1'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    resumed    = '{4'h6, 4'h8, 4'h9, 4'hE, 1'b0, 7'b0000010, 7'b0000000, 7'b0010000, 7'b0000110};

    reset = 1'b0;
    faA = 4'h0; faB = 4'h0; faC = 4'h0; faD = 4'h0; blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d an1", i), 32'(an1), 32'h0F);
      check($sformatf("rst%0d seg1", i), 32'(seg1), 32'h7F);
      check($sformatf("rst%0d tick1", i), 32'(tick1), 32'd0);
      $display("reset cycle %0d an1=%b seg1=%b", i, an1, seg1);
    end
    reset = 1'b1;

    for (int v = 0; v < 9; v++) runFrame(vecs[v], $sformatf("frame%0d", v));

    // Advance into slot C (idx=2, cnt=2), then reset mid-slot.
    for (int i = 0; i < 10; i++) step();
    check("pre-rst an1", 32'(an1), 32'(AN_ON[2]));
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("midrst%0d an1", i), 32'(an1), 32'h0F);
      check($sformatf("midrst%0d an0", i), 32'(an0), 32'h0F);
      check($sformatf("midrst%0d seg1", i), 32'(seg1), 32'h7F);
      check($sformatf("midrst%0d tick1", i), 32'(tick1), 32'd0);
      $display("mid reset cycle %0d an1=%b an0=%b seg1=%b", i, an1, an0, seg1);
    end
    reset = 1'b1;
    runFrame(afterReset, "postrst");
    runFrame(resumed, "resumed");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
